mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single memory controller / RAM port between two requesters: instruction fetch (IF) and the load/store unit (LS).
- Sequences each access over a fixed RAM read latency and returns read data to the winning requester.
- Priority is fixed with LS first, plus a starvation guard so IF is not locked out.
- Sits between the core pipeline and the memory controller; the controller's byte-lane and sign-extension logic stays downstream.

Parameters:
- DATA_WIDTH, 32, address/data width.
- RAM_LATENCY, 1, cycles from the first mc_load/mc_store cycle until mc_rdata is valid; must be 1..15.
- STARVE_LIMIT, 4, number of consecutive LS grants while IF is pending before IF is forced to win; must be 1..15.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  synchronous active-low reset.
- if_req  input  1  IF access request; held until if_ack.
- if_addr  input  DATA_WIDTH  IF word address.
- if_ack  output  1  one-cycle pulse: IF request accepted.
- if_rvalid  output  1  one-cycle pulse: if_rdata valid.
- if_rdata  output  DATA_WIDTH  fetched word.
- ls_req  input  1  LS access request; held until ls_ack.
- ls_addr  input  DATA_WIDTH  LS byte address.
- ls_wdata  input  DATA_WIDTH  store data.
- ls_length  input  2  0 = byte, 1 = half, 3 = word.
- ls_store  input  1  1 = store, 0 = load.
- ls_unsigned  input  1  unsigned load.
- ls_ack  output  1  one-cycle pulse: LS request accepted.
- ls_rvalid  output  1  one-cycle pulse: ls_rdata valid; loads only.
- ls_rdata  output  DATA_WIDTH  load result.
- mc_address, mc_wdata  output  DATA_WIDTH  to memory controller.
- mc_length  output  2  to memory controller.
- mc_store, mc_load, mc_unsigned  output  1  to memory controller.
- mc_rdata  input  DATA_WIDTH  read data from memory controller.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on reset_n.
- Reset values: all outputs are 0, state = IDLE, starve counter = 0, latency counter = 0.
- Reset mid-access: the access is abandoned, no ack or rvalid is produced, and state returns to IDLE on the next edge.
- All outputs are registered.
- FSM states:
  - IDLE: evaluate requests and grant one requester.
  - WAIT: drive the access and count latency.
  - DONE: return read data.
- Grant rules in IDLE (cycle N):
  - Only ls_req high: grant LS.
  - Only if_req high: grant IF.
  - Both high: grant IF if starve == STARVE_LIMIT, otherwise grant LS.
  - On grant, latch the request fields into the mc_* registers and move to WAIT.
  - IF grants drive mc_length = 3, mc_unsigned = 0, mc_store = 0, mc_wdata = 0.
- Acknowledge: the matching *_ack is 1 during cycle N+1 only.
- Request holding: the requester may drop or change its request from N+2 onward. Requests seen in WAIT or DONE are ignored, never granted twice.
- WAIT duration: lasts exactly RAM_LATENCY cycles (N+1 .. N+RAM_LATENCY).
  - mc_load is held high throughout WAIT for IF and for LS loads.
  - mc_store is high only in the first WAIT cycle (single write).
  - mc_address, mc_wdata, mc_length and mc_unsigned are stable for the whole WAIT.
- Data capture: mc_rdata is captured at the end of the last WAIT cycle.
- DONE (cycle N+RAM_LATENCY+1):
  - All mc_* strobes are 0.
  - For a load or fetch, the matching *_rvalid = 1 and *_rdata = captured word. *_rdata holds until the next capture for that requester.
  - For a store, no rvalid is produced.
  - Next state is IDLE.
- Throughput: one access per RAM_LATENCY+2 cycles. No pipelining and no outstanding transactions beyond one.
- Starve counter:
  - Increments on each LS grant made while if_req = 1; saturates at STARVE_LIMIT.
  - Clears to 0 on an IF grant, or in any IDLE cycle with if_req = 0.
- Address handling: addresses pass through unmodified. Alignment checking and byte lanes are the memory controller's responsibility.

Test Plan:
- Reset: hold reset_n = 0 for 3 cycles with both reqs high -> all outputs 0, no ack; after release, the first grant is LS.
- Single fetch, RAM_LATENCY = 1: if_req with if_addr = 0x40 at cycle N, mc_rdata = 0xDEADBEEF ->
  - if_ack at N+1;
  - mc_load = 1 and mc_address = 0x40 at N+1;
  - if_rvalid = 1 and if_rdata = 0xDEADBEEF at N+2;
  - IDLE at N+3.
- Store: ls_store = 1, ls_addr = 0x102, ls_wdata = 0x1234, ls_length = 1 -> ls_ack at N+1, mc_store high for exactly one cycle, no ls_rvalid.
- Contention, STARVE_LIMIT = 4: both reqs continuously high -> grant sequence LS, LS, LS, LS, IF, LS...; the counter clears after the IF grant.
- Latency sweep, RAM_LATENCY = 3: LS load, ls_unsigned = 1 -> mc_load high for 3 cycles, ls_rvalid at N+4, mc_unsigned = 1 throughout WAIT.
- Reset in WAIT: assert reset_n = 0 at N+1 of a load -> no ls_rvalid, all mc_* = 0 next cycle; a re-issued request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
//==============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory-controller port between instruction fetch
//               (IF) and the load/store unit (LS). Fixed priority to LS with
//               a starvation guard for IF. Each access is sequenced over a
//               fixed RAM read latency, and read data is returned to the
//               requester that won the grant.
// Ports       : clk, reset_n               - clock, sync active-low reset
//               if_req/if_addr             - fetch request (held until ack)
//               if_ack/if_rvalid/if_rdata  - fetch accept / read return
//               ls_req/ls_addr/ls_wdata/ls_length/ls_store/ls_unsigned
//                                          - load/store request
//               ls_ack/ls_rvalid/ls_rdata  - LS accept / load return
//               mc_*                       - memory-controller request side
//               mc_rdata                   - memory-controller read data
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int RAM_LATENCY  = 1,   // 1..15
    parameter int STARVE_LIMIT = 4    // 1..15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_req,
    input  logic [DATA_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  ls_req,
    input  logic [DATA_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    input  logic [1:0]            ls_length,
    input  logic                  ls_store,
    input  logic                  ls_unsigned,
    output logic                  ls_ack,
    output logic                  ls_rvalid,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic [DATA_WIDTH-1:0] mc_address,
    output logic [DATA_WIDTH-1:0] mc_wdata,
    output logic [1:0]            mc_length,
    output logic                  mc_store,
    output logic                  mc_load,
    output logic                  mc_unsigned,
    input  logic [DATA_WIDTH-1:0] mc_rdata
);

    localparam logic [3:0] c_LAT    = 4'(RAM_LATENCY);
    localparam logic [3:0] c_STARVE = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state,  w_state_nxt;
    logic [3:0]            r_lat,    w_lat_nxt;
    logic [3:0]            r_starve, w_starve_nxt;
    logic                  r_gnt_if, w_gnt_if_nxt;   // current access belongs to IF

    logic                  r_if_ack,      w_if_ack_nxt;
    logic                  r_if_rvalid,   w_if_rvalid_nxt;
    logic [DATA_WIDTH-1:0] r_if_rdata,    w_if_rdata_nxt;
    logic                  r_ls_ack,      w_ls_ack_nxt;
    logic                  r_ls_rvalid,   w_ls_rvalid_nxt;
    logic [DATA_WIDTH-1:0] r_ls_rdata,    w_ls_rdata_nxt;
    logic [DATA_WIDTH-1:0] r_mc_address,  w_mc_address_nxt;
    logic [DATA_WIDTH-1:0] r_mc_wdata,    w_mc_wdata_nxt;
    logic [1:0]            r_mc_length,   w_mc_length_nxt;
    logic                  r_mc_store,    w_mc_store_nxt;
    logic                  r_mc_load,     w_mc_load_nxt;
    logic                  r_mc_unsigned, w_mc_unsigned_nxt;

    // IF wins when it is alone, or when LS has been favoured STARVE_LIMIT
    // times in a row while IF was waiting.
    logic w_grant_if;
    logic w_grant_ls;
    assign w_grant_if = if_req && (!ls_req || (r_starve == c_STARVE));
    assign w_grant_ls = ls_req && !w_grant_if;

    always_comb begin
        w_state_nxt       = r_state;
        w_lat_nxt         = r_lat;
        w_starve_nxt      = r_starve;
        w_gnt_if_nxt      = r_gnt_if;
        w_if_ack_nxt      = 1'b0;
        w_if_rvalid_nxt   = 1'b0;
        w_if_rdata_nxt    = r_if_rdata;
        w_ls_ack_nxt      = 1'b0;
        w_ls_rvalid_nxt   = 1'b0;
        w_ls_rdata_nxt    = r_ls_rdata;
        w_mc_address_nxt  = r_mc_address;
        w_mc_wdata_nxt    = r_mc_wdata;
        w_mc_length_nxt   = r_mc_length;
        w_mc_unsigned_nxt = r_mc_unsigned;
        w_mc_store_nxt    = 1'b0;          // single-cycle write strobe
        w_mc_load_nxt     = r_mc_load;

        case (r_state)
            ST_IDLE: begin
                w_mc_load_nxt = 1'b0;
                if (!if_req) begin
                    w_starve_nxt = 4'd0;
                end
                if (w_grant_if) begin
                    w_state_nxt       = ST_WAIT;
                    w_lat_nxt         = 4'd1;
                    w_starve_nxt      = 4'd0;
                    w_gnt_if_nxt      = 1'b1;
                    w_if_ack_nxt      = 1'b1;
                    w_mc_address_nxt  = if_addr;
                    w_mc_wdata_nxt    = '0;
                    w_mc_length_nxt   = 2'd3;
                    w_mc_unsigned_nxt = 1'b0;
                    w_mc_load_nxt     = 1'b1;
                end else if (w_grant_ls) begin
                    w_state_nxt       = ST_WAIT;
                    w_lat_nxt         = 4'd1;
                    w_gnt_if_nxt      = 1'b0;
                    w_ls_ack_nxt      = 1'b1;
                    w_mc_address_nxt  = ls_addr;
                    w_mc_wdata_nxt    = ls_wdata;
                    w_mc_length_nxt   = ls_length;
                    w_mc_unsigned_nxt = ls_unsigned;
                    w_mc_store_nxt    = ls_store;
                    w_mc_load_nxt     = !ls_store;
                    if (if_req && (r_starve != c_STARVE)) begin
                        w_starve_nxt = r_starve + 4'd1;
                    end
                end
            end

            ST_WAIT: begin
                if (r_lat == c_LAT) begin
                    w_state_nxt   = ST_DONE;
                    w_mc_load_nxt = 1'b0;
                    // mc_load is still high here exactly when the access is a read
                    if (r_mc_load) begin
                        if (r_gnt_if) begin
                            w_if_rvalid_nxt = 1'b1;
                            w_if_rdata_nxt  = mc_rdata;
                        end else begin
                            w_ls_rvalid_nxt = 1'b1;
                            w_ls_rdata_nxt  = mc_rdata;
                        end
                    end
                end else begin
                    w_lat_nxt = r_lat + 4'd1;
                end
            end

            ST_DONE: begin
                w_state_nxt   = ST_IDLE;
                w_lat_nxt     = 4'd0;
                w_mc_load_nxt = 1'b0;
            end

            default: begin
                w_state_nxt   = ST_IDLE;
                w_lat_nxt     = 4'd0;
                w_mc_load_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_lat         <= 4'd0;
            r_starve      <= 4'd0;
            r_gnt_if      <= 1'b0;
            r_if_ack      <= 1'b0;
            r_if_rvalid   <= 1'b0;
            r_if_rdata    <= '0;
            r_ls_ack      <= 1'b0;
            r_ls_rvalid   <= 1'b0;
            r_ls_rdata    <= '0;
            r_mc_address  <= '0;
            r_mc_wdata    <= '0;
            r_mc_length   <= 2'd0;
            r_mc_store    <= 1'b0;
            r_mc_load     <= 1'b0;
            r_mc_unsigned <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_lat         <= w_lat_nxt;
            r_starve      <= w_starve_nxt;
            r_gnt_if      <= w_gnt_if_nxt;
            r_if_ack      <= w_if_ack_nxt;
            r_if_rvalid   <= w_if_rvalid_nxt;
            r_if_rdata    <= w_if_rdata_nxt;
            r_ls_ack      <= w_ls_ack_nxt;
            r_ls_rvalid   <= w_ls_rvalid_nxt;
            r_ls_rdata    <= w_ls_rdata_nxt;
            r_mc_address  <= w_mc_address_nxt;
            r_mc_wdata    <= w_mc_wdata_nxt;
            r_mc_length   <= w_mc_length_nxt;
            r_mc_store    <= w_mc_store_nxt;
            r_mc_load     <= w_mc_load_nxt;
            r_mc_unsigned <= w_mc_unsigned_nxt;
        end
    end

    assign if_ack      = r_if_ack;
    assign if_rvalid   = r_if_rvalid;
    assign if_rdata    = r_if_rdata;
    assign ls_ack      = r_ls_ack;
    assign ls_rvalid   = r_ls_rvalid;
    assign ls_rdata    = r_ls_rdata;
    assign mc_address  = r_mc_address;
    assign mc_wdata    = r_mc_wdata;
    assign mc_length   = r_mc_length;
    assign mc_store    = r_mc_store;
    assign mc_load     = r_mc_load;
    assign mc_unsigned = r_mc_unsigned;

endmodule

`default_nettype wire
